// File: rtl/pattern_seq.sv
// Timed LED pattern sequencer with valid/ready hand-off of each new word to an I/O-expander writer.
// Define PATTERN_SEQ_ACTLOW_EN to drive wdata inverted (active-low LED sinks); the pattern logic is unchanged.
module pattern_seq #(
  parameter int unsigned       WIDTH   = 16,
  parameter int unsigned       DIV_CNT = 800000,
  parameter logic [WIDTH-1:0]  INIT    = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] wdata,
  output logic             step_pulse,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic             overrun
);

  localparam int unsigned     PW         = $clog2(DIV_CNT);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV_CNT - 1);

  logic [PW-1:0]    presc_reg, presc_next;
  logic [WIDTH-1:0] pattern_reg, pattern_next;
  logic             dir_reg, dir_next;
  logic             step_pulse_reg, step_pulse_next;
  logic             wr_valid_reg, wr_valid_next;
  logic             overrun_reg, overrun_next;
  logic             step;
  logic [WIDTH-1:0] rol, ror;

  // Rotations are pure wiring, so build them bit by bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rot
      assign rol[gi] = pattern_reg[(gi + WIDTH - 1) % WIDTH];
      assign ror[gi] = pattern_reg[(gi + 1) % WIDTH];
    end
  endgenerate

  assign step = en && (presc_reg == PRESC_LAST) && !load;

  always_comb begin
    presc_next      = presc_reg;
    pattern_next    = pattern_reg;
    dir_next        = dir_reg;
    step_pulse_next = 1'b0;
    wr_valid_next   = wr_valid_reg && !wr_ready;
    overrun_next    = overrun_reg;

    if (load) begin
      pattern_next  = load_data;
      presc_next    = '0;
      dir_next      = 1'b0;
      wr_valid_next = 1'b1;
      overrun_next  = 1'b0;
    end else if (step) begin
      presc_next      = '0;
      step_pulse_next = 1'b1;
      wr_valid_next   = 1'b1;
      // A step coinciding with acceptance replaces the word cleanly.
      if (wr_valid_reg && !wr_ready) overrun_next = 1'b1;
      case (mode)
        2'd0: pattern_next = rol;
        2'd1: pattern_next = ror;
        2'd2: begin
          if (!dir_reg) begin
            if (pattern_reg[WIDTH-1]) begin
              dir_next     = 1'b1;
              pattern_next = pattern_reg >> 1;
            end else begin
              pattern_next = pattern_reg << 1;
            end
          end else begin
            if (pattern_reg[0]) begin
              dir_next     = 1'b0;
              pattern_next = pattern_reg << 1;
            end else begin
              pattern_next = pattern_reg >> 1;
            end
          end
        end
        default: pattern_next = pattern_reg + 1'b1;
      endcase
    end else if (en) begin
      presc_next = presc_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg      <= '0;
      pattern_reg    <= INIT;
      dir_reg        <= 1'b0;
      step_pulse_reg <= 1'b0;
      wr_valid_reg   <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      presc_reg      <= presc_next;
      pattern_reg    <= pattern_next;
      dir_reg        <= dir_next;
      step_pulse_reg <= step_pulse_next;
      wr_valid_reg   <= wr_valid_next;
      overrun_reg    <= overrun_next;
    end
  end

`ifdef PATTERN_SEQ_ACTLOW_EN
  assign wdata = ~pattern_reg;
`else
  assign wdata = pattern_reg;
`endif
  assign step_pulse = step_pulse_reg;
  assign wr_valid   = wr_valid_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_pattern_seq.sv
// Directed bench for pattern_seq (WIDTH=8, DIV_CNT=4, INIT=01); wdata expectations follow PATTERN_SEQ_ACTLOW_EN.
module tb_pattern_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_data;
  logic [7:0] wdata;
  logic       step_pulse;
  logic       wr_valid;
  logic       wr_ready;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] cur;

  pattern_seq #(.WIDTH(8), .DIV_CNT(4), .INIT(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .load_data(load_data), .wdata(wdata), .step_pulse(step_pulse),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_w(input logic [7:0] p);
`ifdef PATTERN_SEQ_ACTLOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-14s got %0h ok", tag, obs);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits n_before idle cycles (pattern must hold), then expects the step on the next edge.
  task automatic step_chk(input int n_before, input logic [7:0] exp_p, input string tag);
    repeat (n_before) tick();
    check({tag, "_hold"}, wdata, exp_w(cur));
    check({tag, "_nopls"}, step_pulse, 1'b0);
    tick();
    check({tag, "_wdata"}, wdata, exp_w(exp_p));
    check({tag, "_pulse"}, step_pulse, 1'b1);
    cur = exp_p;
  endtask

  task automatic do_load(input logic [7:0] d, input string tag);
    load = 1'b1;
    load_data = d;
    tick();
    load = 1'b0;
    check({tag, "_wdata"}, wdata, exp_w(d));
    check({tag, "_pulse"}, step_pulse, 1'b0);
    check({tag, "_valid"}, wr_valid, 1'b1);
    check({tag, "_ovr"}, overrun, 1'b0);
    cur = d;
  endtask

  logic [7:0] bounce_tab [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] rotl_tab [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

  initial begin
    // Reset must win over a simultaneous load and en.
    rst_n = 1'b0; en = 1'b1; mode = 2'd0; load = 1'b1; load_data = 8'hFF; wr_ready = 1'b1;
    repeat (2) tick();
    check("rst_wdata", wdata, exp_w(8'h01));
    check("rst_pulse", step_pulse, 1'b0);
    check("rst_valid", wr_valid, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    cur = 8'h01;
    load = 1'b0;
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      step_chk(3, rotl_tab[k], "rotl");
      check("rotl_ovr", overrun, 1'b0);
    end
    tick();
    check("rotl_vclr", wr_valid, 1'b0);

    // Mode switch lands between steps; prescaler is now 1.
    mode = 2'd2;
    step_chk(2, bounce_tab[0], "bounce");
    for (int k = 1; k < 15; k++) step_chk(3, bounce_tab[k], "bounce");

    do_load(8'hFF, "ldff");
    mode = 2'd3;
    step_chk(3, 8'h00, "cnt_wrap");
    step_chk(3, 8'h01, "cnt");

    tick();
    check("hs_vclr", wr_valid, 1'b0);
    wr_ready = 1'b0;
    mode = 2'd0;
    step_chk(2, 8'h02, "ovr1");
    check("ovr1_valid", wr_valid, 1'b1);
    check("ovr1_ovr", overrun, 1'b0);
    step_chk(3, 8'h04, "ovr2");
    check("ovr2_valid", wr_valid, 1'b1);
    check("ovr2_ovr", overrun, 1'b1);
    do_load(8'hA5, "lda5");

    // Step coinciding with acceptance: valid stays, no overrun.
    repeat (3) tick();
    check("acc_pend", wr_valid, 1'b1);
    wr_ready = 1'b1;
    tick();
    check("acc_wdata", wdata, exp_w(8'h4B));
    check("acc_pulse", step_pulse, 1'b1);
    check("acc_valid", wr_valid, 1'b1);
    check("acc_ovr", overrun, 1'b0);
    cur = 8'h4B;
    tick();
    check("acc_vclr", wr_valid, 1'b0);

    // Load on the step edge (prescaler reaches 3 after two more edges).
    repeat (2) tick();
    do_load(8'h3C, "ld_step");
    step_chk(3, 8'h78, "after_ld");

    repeat (2) tick();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("en0_wdata", wdata, exp_w(8'h78));
      check("en0_pulse", step_pulse, 1'b0);
    end
    en = 1'b1;
    step_chk(1, 8'hF0, "en_resume");

    mode = 2'd1;
    step_chk(3, 8'h78, "rotr");
    step_chk(3, 8'h3C, "rotr");

    mode = 2'd0;
    do_load(8'h00, "ld00");
    repeat (4) tick();
    check("zero_hold", wdata, exp_w(8'h00));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
